// File: rtl/readout_sequencer.sv
// Event readout sequencer: streams captured RAM samples per channel.
// Optional READOUT_HEADER_EN macro prepends a 4-byte header.
module readout_sequencer #(
  parameter int ram_width = 10,
  parameter int RD_LAT    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 readout_req,
  input  logic                 data_ready,
  input  logic [ram_width-1:0] wraddress_triggerpoint,
  input  logic [ram_width-1:0] pretrig,
  input  logic [ram_width-1:0] nsmp,
  input  logic [3:0]           chanmask,
  input  logic [7:0]           rddata1,
  input  logic [7:0]           rddata2,
  input  logic [7:0]           rddata3,
  input  logic [7:0]           rddata4,
  output logic                 rden,
  output logic [ram_width-1:0] rdaddress,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done
);

  typedef logic [ram_width-1:0] addr_t;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_HEADER = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  logic [2:0] state;
  addr_t      start_addr;
  addr_t      nsmp_q;
  logic [3:0] mask_q;
  addr_t      addr;
  addr_t      cnt;
  logic [1:0] ch;
  logic [1:0] rdchan;

  logic [RD_LAT-1:0] vld;
  logic [1:0]        cp [RD_LAT];

  logic [7:0] mem [4];
  logic [1:0] wptr;
  logic [1:0] rptr;
  logic [2:0] count;

  logic       pop;
  logic       push;
  logic       push_h;
  logic [7:0] hbyte;
  logic [7:0] sdata;
  logic [7:0] pbyte;
  logic [3:0] inflight;
  logic [3:0] used;
  logic       space;
  logic       lastbyte;
  logic [2:0] nch;
  logic [2:0] fst;
  addr_t      start_in;

  // Lowest enabled channel at or above index "from"; 4 means none left.
  function automatic logic [2:0] first_set(input logic [3:0] m,
                                           input logic [2:0] from);
    logic [2:0] r;
    r = 3'd4;
    for (int i = 3; i >= 0; i--)
      if (m[i] && (3'(i) >= from)) r = 3'(i);
    return r;
  endfunction

  assign tx_valid = (count != 3'd0);
  assign tx_data  = mem[rptr];
  assign pop      = tx_valid & tx_ready;
  assign lastbyte = (cnt == nsmp_q - addr_t'(1));
  assign nch      = first_set(mask_q, {1'b0, ch} + 3'd1);
  assign fst      = first_set(chanmask, 3'd0);
  assign start_in = wraddress_triggerpoint - pretrig;

  // Reads issued but not yet landed in the FIFO, plus FIFO occupancy.
  always_comb begin
    inflight = {3'b0, rden};
    for (int i = 0; i < RD_LAT; i++)
      inflight = inflight + {3'b0, vld[i]};
    used  = {1'b0, count} + inflight;
    space = (used - {3'b0, pop}) < 4'd4;
  end

  // Return-data channel select, aligned with the read pipeline.
  always_comb begin
    sdata = rddata1;
    case (cp[RD_LAT-1])
      2'd1:    sdata = rddata2;
      2'd2:    sdata = rddata3;
      2'd3:    sdata = rddata4;
      default: sdata = rddata1;
    endcase
  end

`ifdef READOUT_HEADER_EN
  logic [1:0]  hidx;
  logic [15:0] nsmp16;

  assign nsmp16 = 16'(nsmp_q);
  assign push_h = (state == S_HEADER) && ((count != 3'd4) || pop);

  // Header byte for the current header slot.
  always_comb begin
    hbyte = 8'hA5;
    case (hidx)
      2'd1:    hbyte = {4'b0, mask_q};
      2'd2:    hbyte = nsmp16[15:8];
      2'd3:    hbyte = nsmp16[7:0];
      default: hbyte = 8'hA5;
    endcase
  end
`else
  assign push_h = 1'b0;
  assign hbyte  = 8'h00;
`endif

  assign push  = vld[RD_LAT-1] | push_h;
  assign pbyte = vld[RD_LAT-1] ? sdata : hbyte;

  // Sequencer FSM: header, read issue with credit check, drain, done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      start_addr <= '0;
      nsmp_q     <= '0;
      mask_q     <= '0;
      addr       <= '0;
      cnt        <= '0;
      ch         <= '0;
      rdchan     <= '0;
      rden       <= 1'b0;
      rdaddress  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef READOUT_HEADER_EN
      hidx       <= '0;
`endif
    end else begin
      rden <= 1'b0;
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (readout_req && data_ready) begin
            start_addr <= start_in;
            addr       <= start_in;
            nsmp_q     <= nsmp;
            mask_q     <= chanmask;
            cnt        <= '0;
            ch         <= fst[1:0];
            busy       <= 1'b1;
`ifdef READOUT_HEADER_EN
            hidx       <= '0;
            state      <= S_HEADER;
`else
            state <= (nsmp == '0 || chanmask == 4'd0) ? S_DRAIN : S_READ;
`endif
          end
        end
        S_HEADER: begin
`ifdef READOUT_HEADER_EN
          if (push_h) begin
            hidx <= hidx + 2'd1;
            if (hidx == 2'd3)
              state <= (nsmp_q == '0 || mask_q == 4'd0) ? S_DRAIN : S_READ;
          end
`else
          state <= S_IDLE;
`endif
        end
        S_READ: begin
          if (space) begin
            rden      <= 1'b1;
            rdaddress <= addr;
            rdchan    <= ch;
            if (lastbyte) begin
              cnt  <= '0;
              addr <= start_addr;
              if (nch[2]) state <= S_DRAIN;
              else        ch    <= nch[1:0];
            end else begin
              cnt  <= cnt + addr_t'(1);
              addr <= addr + addr_t'(1);
            end
          end
        end
        S_DRAIN: begin
          if (count == 3'd0 && inflight == 4'd0) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read-latency pipeline tracking valid reads and their channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld <= '0;
      for (int i = 0; i < RD_LAT; i++) cp[i] <= '0;
    end else begin
      vld[0] <= rden;
      cp[0]  <= rdchan;
      for (int i = 1; i < RD_LAT; i++) begin
        vld[i] <= vld[i-1];
        cp[i]  <= cp[i-1];
      end
    end
  end

  // Four-entry output FIFO feeding the byte sink.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= pbyte;
        wptr      <= wptr + 2'd1;
      end
      if (pop) rptr <= rptr + 2'd1;
      count <= count + {2'b0, push} - {2'b0, pop};
    end
  end

endmodule

// File: tb/tb_readout_sequencer.sv
// Self-checking bench for readout_sequencer with a latency-2 RAM model
// and a queue-based reference of the expected byte and address streams.
module tb_readout_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       readout_req = 1'b0;
  logic       data_ready = 1'b0;
  logic [9:0] wraddress_triggerpoint = '0;
  logic [9:0] pretrig = '0;
  logic [9:0] nsmp = '0;
  logic [3:0] chanmask = '0;
  logic [7:0] rddata1, rddata2, rddata3, rddata4;
  logic       rden;
  logic [9:0] rdaddress;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       busy;
  logic       done;

`ifdef READOUT_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif

  readout_sequencer #(.ram_width(10), .RD_LAT(2)) dut (
    .clk(clk), .reset(reset), .readout_req(readout_req),
    .data_ready(data_ready),
    .wraddress_triggerpoint(wraddress_triggerpoint),
    .pretrig(pretrig), .nsmp(nsmp), .chanmask(chanmask),
    .rddata1(rddata1), .rddata2(rddata2),
    .rddata3(rddata3), .rddata4(rddata4),
    .rden(rden), .rdaddress(rdaddress),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [4][1024];
  logic [9:0] a_q;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  // Synchronous RAM with two clocks from address to data.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    a_q <= rdaddress;
    rddata1 <= ram[0][a_q];
    rddata2 <= ram[1][a_q];
    rddata3 <= ram[2][a_q];
    rddata4 <= ram[3][a_q];
  end

  int obs_b[$];
  int obs_a[$];
  int obs_t[$];
  int exp_b[$];
  int exp_a[$];
  int done_cnt = 0;
  int stall_err = 0;
  bit prev_stall = 0;
  logic [7:0] prev_data;

  // Sink-side monitor: accepted bytes, issued addresses, done, stability.
  always @(negedge clk) begin
    if (reset) prev_stall = 0;
    else begin
      if (prev_stall && (!tx_valid || tx_data !== prev_data))
        stall_err++;
      prev_stall = tx_valid && !tx_ready;
      prev_data = tx_data;
      if (tx_valid && tx_ready) begin
        obs_b.push_back(int'(tx_data));
        obs_t.push_back(cyc);
      end
      if (rden) obs_a.push_back(int'(rdaddress));
      if (done) done_cnt++;
    end
  end

  function automatic int qdiff(input int a[$], input int b[$]);
    int d;
    d = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
    for (int i = 0; i < a.size() && i < b.size(); i++)
      if (a[i] != b[i]) d++;
    return d;
  endfunction

  // Reference: header then each enabled channel's window in address order.
  task automatic build_exp(input logic [9:0] trig, input logic [9:0] pre,
                           input logic [9:0] n, input logic [3:0] m);
    int s;
    exp_b.delete();
    exp_a.delete();
    if (HDR_EN) begin
      exp_b.push_back(8'hA5);
      exp_b.push_back(int'(m));
      exp_b.push_back(int'(n) / 256);
      exp_b.push_back(int'(n) % 256);
    end
    s = (int'(trig) - int'(pre) + 1024) % 1024;
    for (int c = 0; c < 4; c++)
      if (m[c])
        for (int i = 0; i < int'(n); i++) begin
          exp_a.push_back((s + i) % 1024);
          exp_b.push_back(int'(ram[c][(s + i) % 1024]));
        end
  endtask

  task automatic do_readout(input logic [9:0] trig, input logic [9:0] pre,
                            input logic [9:0] n, input logic [3:0] m,
                            input int duty, input int inject_at,
                            output bit tmo, output bit busy_inj);
    obs_b.delete();
    obs_a.delete();
    obs_t.delete();
    busy_inj = 0;
    @(posedge clk); #1;
    wraddress_triggerpoint = trig;
    pretrig = pre;
    nsmp = n;
    chanmask = m;
    data_ready = 1'b1;
    readout_req = 1'b1;
    @(posedge clk); #1;
    readout_req = 1'b0;
    wraddress_triggerpoint = 10'($urandom);
    pretrig = 10'($urandom);
    nsmp = 10'($urandom);
    chanmask = 4'($urandom);
    tmo = 1;
    for (int c = 0; c < 8000; c++) begin
      tx_ready = ($urandom_range(0, 99) < duty);
      readout_req = (c == inject_at);
      @(posedge clk); #1;
      if (c == inject_at) busy_inj = busy;
      readout_req = 1'b0;
      if (done) begin
        tmo = 0;
        break;
      end
    end
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (rden !== 1'b0) begin n_bad++;
      $display("FAIL reset_rden got %b want 0", rden); end
    n_cmp++; if (rdaddress !== 10'd0) begin n_bad++;
      $display("FAIL reset_rdaddress got %0d want 0", rdaddress); end
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++;
      $display("FAIL reset_tx_valid got %b want 0", tx_valid); end
    n_cmp++; if (tx_data !== 8'h00) begin n_bad++;
      $display("FAIL reset_tx_data got %h want 00", tx_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++;
      $display("FAIL reset_done got %b want 0", done); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    bit tmo, bi;
    int d0;
    d0 = done_cnt;
    build_exp(10'd100, 10'd3, 10'd8, 4'b0101);
    do_readout(10'd100, 10'd3, 10'd8, 4'b0101, 100, -1, tmo, bi);
    n_cmp++; if (tmo !== 1'b0) begin n_bad++;
      $display("FAIL basic_timeout got %b want 0", tmo); end
    n_cmp++; if (obs_b.size() !== exp_b.size()) begin n_bad++;
      $display("FAIL basic_count got %0d want %0d", obs_b.size(), exp_b.size()); end
    n_cmp++; if (qdiff(obs_b, exp_b) !== 0) begin n_bad++;
      $display("FAIL basic_bytes got %0d diffs want 0", qdiff(obs_b, exp_b)); end
    n_cmp++; if (qdiff(obs_a, exp_a) !== 0) begin n_bad++;
      $display("FAIL basic_addr got %0d diffs want 0", qdiff(obs_a, exp_a)); end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++;
      $display("FAIL basic_done got %0d want 1", done_cnt - d0); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL basic_busy_after got %b want 0", busy); end
  endtask

  task automatic test_wrap;
    bit tmo, bi;
    int want_a[$];
    want_a = '{1021, 1022, 1023, 0, 1, 2};
    build_exp(10'd2, 10'd5, 10'd6, 4'b0001);
    do_readout(10'd2, 10'd5, 10'd6, 4'b0001, 100, -1, tmo, bi);
    n_cmp++; if (qdiff(obs_a, want_a) !== 0) begin n_bad++;
      $display("FAIL wrap_addr got %0d diffs size %0d want 0 diffs",
               qdiff(obs_a, want_a), obs_a.size()); end
    n_cmp++; if (qdiff(obs_b, exp_b) !== 0) begin n_bad++;
      $display("FAIL wrap_bytes got %0d diffs want 0", qdiff(obs_b, exp_b)); end
  endtask

  task automatic test_stall;
    bit tmo, bi;
    int s0;
    s0 = stall_err;
    build_exp(10'd500, 10'd20, 10'd64, 4'b1111);
    do_readout(10'd500, 10'd20, 10'd64, 4'b1111, 30, -1, tmo, bi);
    n_cmp++; if (tmo !== 1'b0) begin n_bad++;
      $display("FAIL stall_timeout got %b want 0", tmo); end
    n_cmp++; if (obs_b.size() !== exp_b.size()) begin n_bad++;
      $display("FAIL stall_count got %0d want %0d", obs_b.size(), exp_b.size()); end
    n_cmp++; if (qdiff(obs_b, exp_b) !== 0) begin n_bad++;
      $display("FAIL stall_bytes got %0d diffs want 0", qdiff(obs_b, exp_b)); end
    n_cmp++; if (stall_err - s0 !== 0) begin n_bad++;
      $display("FAIL stall_stable got %0d changes want 0", stall_err - s0); end
  endtask

  task automatic test_throughput;
    bit tmo, bi;
    int span;
    build_exp(10'd37, 10'd0, 10'd64, 4'b1111);
    do_readout(10'd37, 10'd0, 10'd64, 4'b1111, 100, -1, tmo, bi);
    span = (obs_t.size() > 0) ? obs_t[obs_t.size()-1] - obs_t[0] : -1;
    n_cmp++; if (span !== exp_b.size() - 1) begin n_bad++;
      $display("FAIL thru_span got %0d want %0d", span, exp_b.size() - 1); end
    n_cmp++; if (qdiff(obs_b, exp_b) !== 0) begin n_bad++;
      $display("FAIL thru_bytes got %0d diffs want 0", qdiff(obs_b, exp_b)); end
  endtask

  task automatic test_ignore;
    bit tmo, bi;
    int na, d0;
    na = obs_a.size();
    @(posedge clk); #1;
    data_ready = 1'b0;
    readout_req = 1'b1;
    nsmp = 10'd5;
    chanmask = 4'b1111;
    @(posedge clk); #1;
    readout_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL ignore_notready_busy got %b want 0", busy); end
    n_cmp++; if (obs_a.size() - na !== 0) begin n_bad++;
      $display("FAIL ignore_notready_reads got %0d want 0", obs_a.size() - na); end
    d0 = done_cnt;
    build_exp(10'd300, 10'd10, 10'd12, 4'b0110);
    do_readout(10'd300, 10'd10, 10'd12, 4'b0110, 50, 8, tmo, bi);
    n_cmp++; if (bi !== 1'b1) begin n_bad++;
      $display("FAIL ignore_busy_held got %b want 1", bi); end
    n_cmp++; if (qdiff(obs_b, exp_b) !== 0) begin n_bad++;
      $display("FAIL ignore_bytes got %0d diffs want 0", qdiff(obs_b, exp_b)); end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++;
      $display("FAIL ignore_done got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid;
    bit tmo, bi;
    int nb, d0;
    @(posedge clk); #1;
    wraddress_triggerpoint = 10'd700;
    pretrig = 10'd4;
    nsmp = 10'd64;
    chanmask = 4'b1111;
    data_ready = 1'b1;
    readout_req = 1'b1;
    @(posedge clk); #1;
    readout_req = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tx_ready = ($urandom_range(0, 99) < 60);
      @(posedge clk); #1;
    end
    reset = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    n_cmp++; if (tx_valid !== 1'b0) begin n_bad++;
      $display("FAIL rstmid_tx_valid got %b want 0", tx_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++;
      $display("FAIL rstmid_busy got %b want 0", busy); end
    n_cmp++; if (rden !== 1'b0) begin n_bad++;
      $display("FAIL rstmid_rden got %b want 0", rden); end
    reset = 1'b0;
    tx_ready = 1'b1;
    nb = obs_b.size();
    repeat (20) @(posedge clk);
    #1;
    n_cmp++; if (obs_b.size() - nb !== 0) begin n_bad++;
      $display("FAIL rstmid_bytes got %0d want 0", obs_b.size() - nb); end
    n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++;
      $display("FAIL rstmid_done got %0d want 0", done_cnt - d0); end
    build_exp(10'd11, 10'd30, 10'd9, 4'b1010);
    do_readout(10'd11, 10'd30, 10'd9, 4'b1010, 70, -1, tmo, bi);
    n_cmp++; if (qdiff(obs_b, exp_b) !== 0) begin n_bad++;
      $display("FAIL rstmid_fresh got %0d diffs want 0", qdiff(obs_b, exp_b)); end
  endtask

  task automatic test_zero;
    bit tmo, bi;
    int d0;
    for (int k = 0; k < 2; k++) begin
      logic [9:0] n;
      logic [3:0] m;
      n = (k == 0) ? 10'd0 : 10'd7;
      m = (k == 0) ? 4'b1111 : 4'b0000;
      d0 = done_cnt;
      build_exp(10'd50, 10'd2, n, m);
      do_readout(10'd50, 10'd2, n, m, 100, -1, tmo, bi);
      n_cmp++; if (qdiff(obs_b, exp_b) !== 0) begin n_bad++;
        $display("FAIL zero%0d_bytes got %0d bytes want %0d",
                 k, obs_b.size(), exp_b.size()); end
      n_cmp++; if (obs_a.size() !== 0) begin n_bad++;
        $display("FAIL zero%0d_reads got %0d want 0", k, obs_a.size()); end
      n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++;
        $display("FAIL zero%0d_done got %0d want 1", k, done_cnt - d0); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++;
        $display("FAIL zero%0d_busy got %b want 0", k, busy); end
    end
  endtask

  task automatic test_random;
    bit tmo, bi;
    logic [9:0] t, p, n;
    logic [3:0] m;
    int duty;
    for (int k = 0; k < 4; k++) begin
      t = 10'($urandom);
      p = 10'($urandom);
      n = 10'($urandom_range(1, 40));
      m = 4'($urandom_range(1, 15));
      duty = $urandom_range(20, 100);
      build_exp(t, p, n, m);
      do_readout(t, p, n, m, duty, -1, tmo, bi);
      n_cmp++; if (qdiff(obs_b, exp_b) !== 0) begin n_bad++;
        $display("FAIL rand%0d_bytes got %0d diffs want 0",
                 k, qdiff(obs_b, exp_b)); end
      n_cmp++; if (qdiff(obs_a, exp_a) !== 0) begin n_bad++;
        $display("FAIL rand%0d_addr got %0d diffs want 0",
                 k, qdiff(obs_a, exp_a)); end
    end
  endtask

  initial begin
    for (int c = 0; c < 4; c++)
      for (int a = 0; a < 1024; a++)
        ram[c][a] = 8'($urandom);
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_throughput();
    test_ignore();
    test_reset_mid();
    test_zero();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/readout_sequencer.md
READOUT_SEQUENCER -- requirements
Module: readout_sequencer

Interface
REQ-001 Parameter ram_width, default 10, RAM address width; RD_LAT, default 2, RAM read latency in clocks (address to rddata).
REQ-002 clk  in  1  sole clock; all logic on posedge clk; synchronous active-high reset.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 readout_req  in  1  one-cycle pulse requesting readout of the captured event.
REQ-005 data_ready  in  1  capture complete, RAM contents valid.
REQ-006 wraddress_triggerpoint  in  ram_width  RAM address at trigger.
REQ-007 pretrig  in  ram_width  samples to read before trigger address.
REQ-008 nsmp  in  ram_width  samples per channel to send.
REQ-009 chanmask  in  4  channels to send, bit0 = channel 1.
REQ-010 rddata1..rddata4  in  8 each  RAM read data per channel.
REQ-011 rden  out  1  RAM read enable.
REQ-012 rdaddress  out  ram_width  RAM read address.
REQ-013 tx_data  out  8  output byte.
REQ-014 tx_valid  out  1  tx_data valid.
REQ-015 tx_ready  in  1  sink accepts byte when tx_valid & tx_ready.
REQ-016 busy  out  1  high from accepted request until done.
REQ-017 done  out  1  one-cycle pulse after last byte accepted.

Function
REQ-018 States IDLE, HEADER, READ, DRAIN, DONE; IDLE->HEADER (or READ without header) on readout_req & data_ready; readout_req with data_ready=0 or while busy is ignored.
REQ-019 Inputs pretrig, nsmp, chanmask, wraddress_triggerpoint captured on request acceptance; later changes have no effect on the readout.
REQ-020 Start address = wraddress_triggerpoint - pretrig, modulo 2^ram_width; address increments by 1 per read, wrapping 2^ram_width-1 -> 0.
REQ-021 Channels sent in ascending order, masked ones skipped; each sent channel restarts at start address; nsmp bytes per channel.
REQ-022 rddata selected by channel index delayed RD_LAT clocks alongside address.
REQ-023 4-entry output FIFO; read issued only when FIFO occupancy plus reads in flight < 4; no byte lost or duplicated under any tx_ready pattern.
REQ-024 tx_valid held with tx_data stable until accepted; byte order strictly address order.
REQ-025 READ->DRAIN after last read issued; DRAIN->DONE when FIFO empty and nothing in flight; DONE asserts done for one cycle, ->IDLE.
REQ-026 nsmp=0 or chanmask=0: no RAM reads, no sample bytes; header (if enabled) still sent, then done.
REQ-027 With continuous tx_ready, sustained throughput one byte per clock after initial RD_LAT+1 fill.
REQ-028 rden high exactly in cycles a read is issued.

Reset
REQ-029 Reset: state IDLE, FIFO and in-flight count cleared, rden=0, rdaddress=0, tx_valid=0, tx_data=0, busy=0, done=0.
REQ-030 Reset mid-readout aborts immediately; no further bytes, no done pulse; in-flight RAM data discarded.

Configuration
REQ-031 Macro READOUT_HEADER_EN: when defined, 4-byte header precedes samples: 0xA5, {4'b0,chanmask}, {6'b0,nsmp[9:8]}, nsmp[7:0] (upper bits per ram_width); when undefined, no header, IDLE->READ directly.

Verification
REQ-032 Header on, chanmask=4'b0101, nsmp=8, trigpoint=100, pretrig=3, tx_ready=1 -> A5,05,00,08, ch1 addr 97..104, ch3 addr 97..104, done once, 20 bytes.
REQ-033 trigpoint=2, pretrig=5, nsmp=6, chanmask=0001 -> addresses 1021,1022,1023,0,1,2.
REQ-034 tx_ready random 30% duty, nsmp=64, chanmask=1111 -> 256 sample bytes exact order, no loss/duplication, data stable while stalled.
REQ-035 readout_req with data_ready=0, and second readout_req while busy -> both ignored, busy unchanged.
REQ-036 reset asserted mid-READ -> next cycle tx_valid=0, busy=0, rden=0; no done; fresh request then reads correctly.
REQ-037 Header off, nsmp=0 -> zero bytes, done pulses, busy drops.
